// File: rtl/board_view_pkg.sv
// Shared definitions for the board view renderer: FSM states, palette colours
// and the layout of a board RAM cell.
package board_view_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_ADDR,
    S_LATCH,
    S_DRAW,
    S_DONE
  } view_state_e;

  localparam logic [2:0] LIGHT    = 3'b110;
  localparam logic [2:0] DARK     = 3'b010;
  localparam logic [2:0] WHITE_PC = 3'b111;
  localparam logic [2:0] BLACK_PC = 3'b000;
  localparam logic [2:0] INVALID  = 3'b101;
  localparam logic [2:0] CURSOR   = 3'b100;

  localparam int SIDE_BIT = 3;
  localparam int TYPE_MSB = 2;
  localparam int TYPE_LSB = 0;

  localparam logic [3:0] EMPTY        = 4'b0000;
  localparam logic [3:0] BLACK_EMPTY  = 4'b1000;
  localparam logic [2:0] TYPE_INVALID = 3'd7;

  // Type 7 and a "black empty" cell are both corrupt board contents.
  function automatic logic piece_is_invalid(input logic [3:0] piece);
    return (piece[TYPE_MSB:TYPE_LSB] == TYPE_INVALID) || (piece == BLACK_EMPTY);
  endfunction

endpackage

// File: rtl/board_piece_palette.sv
// Maps a board cell, square parity, ring flag and cursor hit to a pixel colour.
// Purely combinational so any tile renderer can share it.
module board_piece_palette
  import board_view_pkg::*;
(
  input  logic [3:0] piece_i,
  input  logic       odd_i,
  input  logic       ring_i,
  input  logic       cursor_hit_i,
  output logic [2:0] colour_o
);

  logic [2:0] square_colour;

  assign square_colour = odd_i ? DARK : LIGHT;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    colour_o = square_colour;
    if (ring_i && cursor_hit_i) begin
      colour_o = CURSOR;
    end else if (piece_is_invalid(piece_i)) begin
      colour_o = INVALID;
    end else if ((piece_i == EMPTY) || ring_i) begin
      colour_o = square_colour;
    end else begin
      colour_o = piece_i[SIDE_BIT] ? BLACK_PC : WHITE_PC;
    end
  end

endmodule

// File: rtl/board_view_renderer.sv
// Reads all 64 board squares over the shared RAM view port and paints each as a
// TILE x TILE block on the pixel plot interface. Define VIEW_CURSOR_EN for a cursor ring.
module board_view_renderer
  import board_view_pkg::*;
#(
  parameter int TILE = 8,
  parameter int X0   = 16,
  parameter int Y0   = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       mem_grant,
  input  logic [3:0] piece_read,
`ifdef VIEW_CURSOR_EN
  input  logic [5:0] cursor_addr,
`endif
  output logic [5:0] address_view,
  output logic       mem_req,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] TILE_M1     = 8'(TILE - 1);
  localparam logic [7:0] TILE_X      = 8'(TILE);
  localparam logic [6:0] TILE_Y      = 7'(TILE);
  localparam logic [7:0] X_BASE      = 8'(X0);
  localparam logic [6:0] Y_BASE      = 7'(Y0);
  localparam logic [5:0] LAST_SQUARE = 6'd63;

  view_state_e state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [3:0]  piece_q, piece_d;
  logic        hit_q, hit_d;
  logic [7:0]  px_q, px_d;
  logic [7:0]  py_q, py_d;
  logic [7:0]  x_q, x_d;
  logic [6:0]  y_q, y_d;
  logic [2:0]  colour_q, colour_d;
  logic        plot_q, plot_d;
  logic        busy_q, busy_d;
  logic        mem_req_q, mem_req_d;
  logic        done_q, done_d;

  logic [2:0]  row, col;
  logic        odd, ring, last_px, last_py, cursor_match;
  logic [7:0]  pix_x;
  logic [6:0]  pix_y;
  logic [2:0]  pix_colour;

  assign row     = idx_q[5:3];
  assign col     = idx_q[2:0];
  assign odd     = row[0] ^ col[0];
  assign last_px = (px_q == TILE_M1);
  assign last_py = (py_q == TILE_M1);
  assign ring    = (px_q == 8'd0) || last_px || (py_q == 8'd0) || last_py;
  assign pix_x   = X_BASE + TILE_X * 8'(col) + px_q;
  assign pix_y   = Y_BASE + TILE_Y * 7'(row) + py_q[6:0];

`ifdef VIEW_CURSOR_EN
  assign cursor_match = (cursor_addr == idx_q);
`else
  assign cursor_match = 1'b0;
`endif

  board_piece_palette u_palette (
    .piece_i      (piece_q),
    .odd_i        (odd),
    .ring_i       (ring),
    .cursor_hit_i (hit_q),
    .colour_o     (pix_colour)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    piece_d  = piece_q;
    hit_d    = hit_q;
    px_d     = px_q;
    py_d     = py_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_REQ;
          idx_d   = 6'd0;
        end
      end
      S_REQ: begin
        if (mem_grant) state_d = S_ADDR;
      end
      S_ADDR: begin
        state_d = mem_grant ? S_LATCH : S_REQ;
      end
      S_LATCH: begin
        // Read data is only trusted while the port is still ours; otherwise retry.
        if (!mem_grant) begin
          state_d = S_REQ;
        end else begin
          piece_d = piece_read;
          hit_d   = cursor_match;
          px_d    = 8'd0;
          py_d    = 8'd0;
          state_d = S_DRAW;
        end
      end
      S_DRAW: begin
        plot_d   = 1'b1;
        x_d      = pix_x;
        y_d      = pix_y;
        colour_d = pix_colour;
        if (!last_px) begin
          px_d = px_q + 8'd1;
        end else begin
          px_d = 8'd0;
          if (!last_py) begin
            py_d = py_q + 8'd1;
          end else if (idx_q == LAST_SQUARE) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 6'd1;
            state_d = mem_grant ? S_ADDR : S_REQ;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered from the next state so they line up with it.
    busy_d    = (state_d != S_IDLE) && (state_d != S_DONE);
    mem_req_d = busy_d;
    done_d    = (state_d == S_DONE);
  end

  // NOTE: synchronous reset, and non-blocking assignments for every sequential register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      piece_q   <= '0;
      hit_q     <= 1'b0;
      px_q      <= '0;
      py_q      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      colour_q  <= '0;
      plot_q    <= 1'b0;
      busy_q    <= 1'b0;
      mem_req_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      piece_q   <= piece_d;
      hit_q     <= hit_d;
      px_q      <= px_d;
      py_q      <= py_d;
      x_q       <= x_d;
      y_q       <= y_d;
      colour_q  <= colour_d;
      plot_q    <= plot_d;
      busy_q    <= busy_d;
      mem_req_q <= mem_req_d;
      done_q    <= done_d;
    end
  end

  assign address_view = idx_q;
  assign mem_req      = mem_req_q;
  assign x            = x_q;
  assign y            = y_q;
  assign colour       = colour_q;
  assign plot         = plot_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
